// File: rtl/div16_pkg.sv
// rtl/div16_pkg.sv - shared constants, state encoding and sizing helper for the sequential divider
package div16_pkg;

    localparam int DIV_WIDTH = 16;

    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div16_fs1b.sv
// rtl/div16_fs1b.sv - 1-bit full subtractor, {Bout, Diff} = A - B - Bin
module fs1b (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/div16_seq.sv
// rtl/div16_seq.sv - restoring sequential divider, one quotient bit per cycle; DIV16_SIGNED_EN adds signed mode
module div16_seq
    import div16_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sgn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int CW = div_cnt_w(WIDTH);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   sub_d;
    logic [WIDTH+1:0] brw;
    logic             restore;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             dz_nxt;
    logic             unused_bits;

    // Trial subtraction of the divisor from the shifted partial remainder
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign sub_b   = {1'b0, dsr_q};
    assign brw[0]  = 1'b0;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        fs1b u_fs1b (
            .A    (shifted[i]),
            .B    (sub_b[i]),
            .Bin  (brw[i]),
            .Diff (sub_d[i]),
            .Bout (brw[i+1])
        );
    end

    // A kept difference is always below the divisor, so its top bit is zero
    assign restore = brw[WIDTH+1];
    assign rem_nxt = restore ? shifted[WIDTH-1:0] : sub_d[WIDTH-1:0];
    assign quo_nxt = {dvd_q[WIDTH-2:0], ~restore};
    assign dz_nxt  = (dsr_q == '0);

`ifdef DIV16_SIGNED_EN
    logic             a_neg;
    logic             b_neg;
    logic             qneg_q;
    logic             rneg_q;
    logic [WIDTH-1:0] orig_q;

    assign a_neg = sgn & dividend[WIDTH-1];
    assign b_neg = sgn & divisor[WIDTH-1];
    assign op_a  = a_neg ? -dividend : dividend;
    assign op_b  = b_neg ? -divisor : divisor;
    assign q_fin = dz_nxt ? '1 : (qneg_q ? -quo_nxt : quo_nxt);
    assign r_fin = dz_nxt ? orig_q : (rneg_q ? -rem_nxt : rem_nxt);
    assign unused_bits = sub_d[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            orig_q <= '0;
        end else if (state == IDLE && start) begin
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            orig_q <= dividend;
        end
    end
`else
    assign op_a  = dividend;
    assign op_b  = divisor;
    assign q_fin = quo_nxt;
    assign r_fin = rem_nxt;
    assign unused_bits = sub_d[WIDTH] ^ sgn;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_q <= op_a;
                        dsr_q <= op_b;
                        rem_q <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rem_q <= rem_nxt;
                    dvd_q <= quo_nxt;
                    cnt   <= cnt + 1'b1;
                    // Results are published as the last bit resolves so they are valid during DONE
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        dz        <= dz_nxt;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div16_seq.sv
// tb/tb_div16_seq.sv - directed and random self-checking bench for div16_seq with a result scoreboard
module tb_div16_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sgn;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic        dz;
    logic [15:0] quotient;
    logic [15:0] remainder;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } res_t;

    res_t sb[$];

    div16_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .sgn       (sgn),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
        res_t r;
        int   sa;
        int   sb_i;
        r.dz = (b == 16'h0);
        if (b == 16'h0) begin
            r.q = 16'hFFFF;
            r.r = a;
        end else begin
            r.q = a / b;
            r.r = a % b;
        end
`ifdef DIV16_SIGNED_EN
        if (s && b != 16'h0) begin
            sa   = $signed(a);
            sb_i = $signed(b);
            if (sa == -32768 && sb_i == -1) begin
                r.q = 16'h8000;
                r.r = 16'h0;
            end else begin
                r.q = 16'(sa / sb_i);
                r.r = 16'(sa % sb_i);
            end
        end
`else
        sa   = 32'(s);
        sb_i = sa;
`endif
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input res_t exp, input bit disturb);
        res_t got_r;
        int   edges;
        int   busy_cnt;
        bit   got;
        sb.push_back(exp);
        dividend = a;
        divisor  = b;
        sgn      = s;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_first"}, 32'(busy), 32'd1);
        edges    = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && edges < 40) begin
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (disturb && edges == 5) begin
                    dividend = 16'($urandom);
                    divisor  = 16'($urandom);
                    sgn      = ~sgn;
                    start    = 1'b1;
                end
                if (disturb && edges == 6) start = 1'b0;
                @(negedge clk);
                edges++;
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(edges + 1), 32'd17);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd17);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        got_r = '0;
        if (sb.size() > 0) got_r = sb.pop_front();
        check({tag, "_quotient"}, 32'(quotient), 32'(got_r.q));
        check({tag, "_remainder"}, 32'(remainder), 32'(got_r.r));
        check({tag, "_dz"}, 32'(dz), 32'(got_r.dz));
        if (disturb) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle_after"}, 32'({busy, done}), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_hold_q"}, 32'({quotient, remainder}), 32'({got_r.q, got_r.r}));
    endtask

    initial begin
        res_t e;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        int          nd;
        int          d1;
        int          d2;
        int          dcount;

        rst_n    = 1'b1;
        start    = 1'b0;
        sgn      = 1'b0;
        dividend = 16'h0;
        divisor  = 16'h0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_state", 32'({busy, done, dz, quotient, remainder}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        e = '{q: 16'd14, r: 16'd2, dz: 1'b0};
        run_op("u100_7", 16'd100, 16'd7, 1'b0, e, 1'b0);

        e = '{q: 16'hFFFF, r: 16'h1234, dz: 1'b1};
        run_op("divzero", 16'h1234, 16'h0000, 1'b0, e, 1'b0);

`ifdef DIV16_SIGNED_EN
        e = '{q: 16'hFFFD, r: 16'hFFFF, dz: 1'b0};
`else
        e = '{q: 16'h7FFC, r: 16'h0001, dz: 1'b0};
`endif
        run_op("neg7_2", 16'hFFF9, 16'h0002, 1'b1, e, 1'b0);

`ifdef DIV16_SIGNED_EN
        e = '{q: 16'h8000, r: 16'h0000, dz: 1'b0};
`else
        e = '{q: 16'h0000, r: 16'h8000, dz: 1'b0};
`endif
        run_op("ovf", 16'h8000, 16'hFFFF, 1'b1, e, 1'b0);

        e = '{q: 16'hFFFF, r: 16'hFFF9, dz: 1'b1};
        run_op("sdivzero", 16'hFFF9, 16'h0000, 1'b1, e, 1'b0);

        e = '{q: 16'hFFFF, r: 16'h0000, dz: 1'b0};
        run_op("midrun", 16'hFFFF, 16'h0001, 1'b0, e, 1'b1);

        // start held high across back-to-back operations
        e = '{q: 16'd14, r: 16'd2, dz: 1'b0};
        sb.push_back(e);
        sb.push_back(e);
        dividend = 16'd100;
        divisor  = 16'd7;
        sgn      = 1'b0;
        start    = 1'b1;
        nd = 0;
        d1 = 0;
        d2 = 0;
        for (int n = 0; n < 60 && nd < 2; n++) begin
            @(negedge clk);
            if (done) begin
                if (nd == 0) d1 = n;
                else begin
                    d2    = n;
                    start = 1'b0;
                end
                nd++;
                check("held_sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("held_quotient", 32'(quotient), 32'(e.q));
                    check("held_remainder", 32'(remainder), 32'(e.r));
                end
            end
        end
        start = 1'b0;
        check("held_done_count", 32'(nd), 32'd2);
        check("held_spacing", 32'(d2 - d1), 32'd18);
        repeat (2) @(negedge clk);
        check("held_idle", 32'(busy), 32'd0);

        // asynchronous reset five cycles into a run
        dividend = 16'd1000;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({busy, done, dz, quotient, remainder}), 32'd0);
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        rst_n = 1'b1;
        e = '{q: 16'd3, r: 16'd0, dz: 1'b0};
        run_op("after_abort", 16'd9, 16'd3, 1'b0, e, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = (i % 2 == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            run_op("random", ra, rb, rs, model(ra, rb, rs), 1'b0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div16_seq.md
DIV16_SEQ -- requirements
Module: div16_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port start, input, 1: request a division; sampled only in IDLE.
REQ-005 Port dividend, input, WIDTH: numerator; latched on accepted start.
REQ-006 Port divisor, input, WIDTH: denominator; latched on accepted start.
REQ-007 Port sgn, input, 1: signed operation request; latched on accepted start.
REQ-008 Port busy, output, 1: high while a division is in progress.
REQ-009 Port done, output, 1: one-cycle pulse when quotient and remainder are valid.
REQ-010 Port quotient, output, WIDTH: result quotient.
REQ-011 Port remainder, output, WIDTH: result remainder.
REQ-012 Port dz, output, 1: the latched divisor was zero; valid with done.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
- IDLE to RUN on start=1.
- RUN to DONE after WIDTH iterations.
- DONE to IDLE unconditionally after one cycle.
REQ-014 Restoring algorithm, one quotient bit per cycle, MSB first.
- Per cycle: shift {rem, dividend} left by 1, then trial-subtract the divisor over WIDTH+1 bits.
- If there is no borrow: keep the difference and set q bit = 1.
- If there is a borrow: restore the partial remainder and set q bit = 0.
REQ-015 Fixed latency regardless of operands, including divide-by-zero.
- busy is high for exactly WIDTH+1 cycles after the edge that samples start.
- done is high in the final of those cycles.
REQ-016 start while busy=1 is ignored; latched operands are unaffected.
REQ-017 quotient, remainder and dz hold their last values until the next accepted start.
REQ-018 Changes on dividend, divisor or sgn after acceptance do not affect the running operation.
REQ-019 Divisor == 0 gives quotient = all ones, remainder = dividend, dz = 1 (RISC-V DIVU/REMU semantics).
REQ-020 start in the DONE cycle is ignored; it is next accepted in IDLE.

Reset
REQ-021 rst_n low forces the following immediately, regardless of clk:
- state = IDLE;
- busy = 0, done = 0, dz = 0;
- quotient = 0, remainder = 0.
REQ-022 Reset during RUN aborts the operation: no done pulse, and partial results are discarded.
REQ-023 The first start is accepted on the first rising edge with rst_n high.

Configuration
REQ-024 Macro DIV16_SIGNED_EN enables signed division.
- Defined: when sgn = 1, operands are converted to magnitudes before iteration and signs are corrected in the DONE cycle.
- Quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
- Signed divide-by-zero: quotient = all ones, remainder = dividend.
- Signed overflow, most-negative / -1: quotient = most-negative, remainder = 0, dz = 0 (RISC-V DIV/REM semantics).
- Not defined: the sgn port is present but ignored, all operations are unsigned, and no sign-correction logic is synthesized.
- Latency is identical in both builds.

Structure
REQ-025 Shared package div16_pkg holds:
- the state enum (IDLE, RUN, DONE);
- the WIDTH default;
- the iteration-counter width, clog2(WIDTH+1).
REQ-026 Sub-module fs1b: 1-bit full subtractor with inputs A, B, Bin and outputs Diff, Bout, where {Bout, Diff} = A - B - Bin.
- WIDTH+1 instances are chained ripple-style to form the trial subtractor.
- The final Bout is the borrow that selects restore or keep.

Verification
REQ-027 Unsigned: dividend=100, divisor=7 -> quotient=14, remainder=2, dz=0; done exactly 17 edges after the edge that sampled start.
REQ-028 Divide-by-zero: dividend=0x1234, divisor=0 -> quotient=0xFFFF, remainder=0x1234, dz=1, same 17-cycle latency.
REQ-029 Signed (DIV16_SIGNED_EN defined):
- -7 / 2 with sgn=1 -> quotient=0xFFFD, remainder=0xFFFF.
- 0x8000 / 0xFFFF with sgn=1 -> quotient=0x8000, remainder=0.
REQ-030 Handshake:
- start held high through a whole operation -> exactly one done per 18 cycles (17 busy + 1 IDLE).
- Operand changes mid-run do not alter 0xFFFF/1 -> quotient=0xFFFF, remainder=0.
REQ-031 Reset abort: assert rst_n low 5 cycles into a run -> outputs 0 immediately, no done pulse; a subsequent 9/3 -> quotient=3, remainder=0.
REQ-032 Build without DIV16_SIGNED_EN: -7 / 2 with sgn=1 -> unsigned result, quotient=0x7FFC, remainder=1.
